// File: rtl/scoreboard_hazard_unit.sv
// rtl/scoreboard_hazard_unit.sv - register scoreboard with per-source bypass select and RAW/WAW/port stall
module scoreboard_hazard_unit #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int MAX_LAT  = 7,
  parameter int LAT_W    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [NUM_SRC*REG_AW-1:0] issue_src,
  input  logic [NUM_SRC-1:0]        issue_src_en,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic                      issue_wen,
  input  logic [LAT_W-1:0]          issue_lat,
  output logic                      stall,
  output logic                      issue_accept,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic [NUM_REGS-1:0]       busy_vec
);

  logic [NUM_REGS-1:0] busy;
  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [MAX_LAT+1:1]  slot;

  logic                 raw, waw, port_hit, hazard, wr;
  logic [NUM_SRC*2-1:0] fwd_raw;

  always_comb begin
    raw     = 1'b0;
    fwd_raw = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (issue_src_en[k] && (issue_src[k*REG_AW +: REG_AW] != '0) &&
          busy[issue_src[k*REG_AW +: REG_AW]]) begin
        if (cnt[issue_src[k*REG_AW +: REG_AW]] >= LAT_W'(2))
          raw = 1'b1;
        else if (cnt[issue_src[k*REG_AW +: REG_AW]] == LAT_W'(1))
          fwd_raw[k*2 +: 2] = 2'b01;
        else
          fwd_raw[k*2 +: 2] = 2'b10;
      end
    end

    wr  = issue_wen && (issue_rd != '0);
    waw = wr && busy[issue_rd] &&
          ({1'b0, cnt[issue_rd]} >= ({1'b0, issue_lat} + (LAT_W+1)'(1)));

    // The write-back slot one beyond the new producer's latency must be free;
    // lat == MAX_LAT looks past the end of the shift register and never conflicts.
    port_hit = 1'b0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (wr && (({1'b0, issue_lat} + (LAT_W+1)'(1)) == (LAT_W+1)'(k)))
        port_hit = slot[k];
    end

    hazard = issue_valid && (raw || waw || port_hit);
  end

  assign stall        = hazard && !reset;
  assign issue_accept = issue_valid && !hazard && !reset;
  assign fwd_sel      = reset ? '0 : fwd_raw;
  assign busy_vec     = reset ? '0 : busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
      slot <= '0;
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (busy[r]) begin
          if (cnt[r] != '0)
            cnt[r] <= cnt[r] - LAT_W'(1);
          else
            busy[r] <= 1'b0;
        end
      end
      slot <= {1'b0, slot[MAX_LAT+1:2]};
      // Later assignments win, so a fresh issue overrides the aging above.
      if (issue_accept && wr) begin
        busy[issue_rd] <= 1'b1;
        cnt[issue_rd]  <= issue_lat;
        for (int k = 1; k <= MAX_LAT; k++) begin
          if (issue_lat == LAT_W'(k))
            slot[k] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/scoreboard_hazard_unit.md
# scoreboard_hazard_unit

Parametrised scoreboard that replaces fixed-latency forwarding and hazard logic once the pipeline contains variable-latency units such as ALU, load, multiply and divide. It tracks every pending register write with a countdown to completion. For each instruction offered at issue it produces, in the same cycle:
- per-source bypass selects;
- a stall for RAW, WAW and write-back-port conflicts.

It sits beside the decode/issue stage and updates its state only on accepted issues.

## Interface
Parameters:
- NUM_REGS, 32: architectural registers; register 0 is hard-wired zero.
- REG_AW, 5: register index width, clog2(NUM_REGS).
- NUM_SRC, 2: source operands per instruction. 3 supports fused ops.
- MAX_LAT, 7: largest legal producer latency.
- LAT_W, 4: counter width, clog2(MAX_LAT+2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  an instruction is offered for issue this cycle.
- issue_src  in  NUM_SRC*REG_AW  packed source indices; src k is at [k*REG_AW +: REG_AW].
- issue_src_en  in  NUM_SRC  per-source "operand is read".
- issue_rd  in  REG_AW  destination register.
- issue_wen  in  1  instruction writes issue_rd.
- issue_lat  in  LAT_W  producer latency, legal range 1..MAX_LAT.
- stall  out  1  hazard present; hold the issuing instruction.
- issue_accept  out  1  issue_valid & ~stall & ~reset.
- fwd_sel  out  NUM_SRC*2  per source, packed like issue_src:
  - 00: register file
  - 01: completion bus
  - 10: write-back bus
  - 11: never driven
- busy_vec  out  NUM_REGS  debug view of the per-register busy bits.

## Operation
State per register r:
- busy[r]
- cnt[r], LAT_W bits

Global state:
- slot[MAX_LAT+1:1], the write-back-port reservation shift register.

Semantics:
- busy & cnt≥2: result not yet produced.
- busy & cnt==1: result is on the completion bus this cycle.
- busy & cnt==0: result is in the write-back register.
- The entry clears at the next edge.

Per-source evaluation applies to each k with issue_src_en[k]=1 and src≠0:
- busy & cnt≥2 → RAW stall.
- busy & cnt==1 → fwd_sel=01.
- busy & cnt==0 → fwd_sel=10.
- otherwise → 00.
- A disabled source, or src==0, always gives 00 and no stall.

Stall is the OR of the following; all terms are qualified by issue_valid, and the last two only when issue_wen=1 and issue_rd≠0:
- any RAW stall;
- WAW: busy[issue_rd] & cnt[issue_rd] ≥ issue_lat+1;
- port conflict: slot[issue_lat+1]==1. Index MAX_LAT+1 is treated as 0.

Every edge, in this order:
1. For each busy entry: if cnt>0, decrement cnt; else clear busy.
2. Shift slot down one: slot[k] ← slot[k+1]; slot[MAX_LAT+1] ← 0.
3. On issue_accept with issue_wen=1 and issue_rd≠0:
   - busy[issue_rd] ← 1 and cnt[issue_rd] ← issue_lat. This overrides step 1 for that register.
   - slot[issue_lat] ← 1.

Other rules:
- An instruction whose source equals its own rd sees the pre-issue state.
- issue_lat outside 1..MAX_LAT is illegal and produces undefined behaviour; the bench asserts against it.

## Timing
- stall, issue_accept and fwd_sel are combinational from registered state plus current inputs; zero-cycle latency.
- A producer of latency L issued at edge e drives the completion bus in the cycle after edge e+L-1 and the write-back bus one cycle later. Its entry clears at edge e+L+1 unless it is re-issued.
- Reset: all busy, cnt and slot bits go to 0. While reset is high:
  - issue_accept=0, stall=0, fwd_sel=0, busy_vec=0;
  - no state update occurs.
- Reset asserted mid-operation discards every pending entry. The first cycle after reset sees an empty scoreboard.
- Stall holds as long as its condition holds. No internal timeout.

## Test plan
- ALU chain: cycle0 issue x5 lat1 → accept. Consumer with rs1=5:
  - cycle1: fwd_sel[1:0]=01, stall=0;
  - cycle2: 10;
  - cycle3: 00 and busy_vec[5]=0.
- Load-use: cycle0 issue x6 lat2. Consumer with rs2=6:
  - cycle1: stall=1;
  - cycle2: stall=0 with fwd_sel[3:2]=01.
- Port conflict: cycle0 issue x7 lat4.
  - cycle2: issue x8 lat2 → stall=1.
  - Same cycle with lat1 instead → accept.
  - cycle3: issue x8 lat2 → accept, since slot[3] is now clear.
- WAW: cycle0 issue x9 lat4; from cycle1, offer x9 lat1.
  - stall=1 in cycles 1–3;
  - accept in cycle4, when cnt[9]=1;
  - consumers of x9 then see 01 in cycle5.
- x0 and disabled sources: issue x0 lat3 → busy_vec stays 0. A source with en=0 that matches a busy register → no stall, fwd 00.
- Reset mid-flight: issue x3 lat5, then assert reset at cycle2 → busy_vec=0 and slot cleared. At cycle3, a consumer of x3 gets fwd 00 and stall=0.
